// File: rtl/apb_slave_regs.sv
// APB completer serving eight 32-bit registers (six R/W, a write counter and an ID)
// with registered pready, programmable wait states and pslverr on illegal accesses.
module apb_slave_regs #(
    parameter int unsigned SEL_BIT     = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [2:0]  pselx,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [31:0] ctrl_out
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic [31:0] wdata_q, wdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] prdata_q, prdata_d;
    logic [31:0] regs_q [6];
    logic [31:0] regs_d [6];
    logic [31:0] wrcnt_q, wrcnt_d;

    logic        sel;
    logic [31:0] off_full;
    logic        setup_err;
    logic        unused_pselx;

    assign sel          = pselx[SEL_BIT];
    assign unused_pselx = ^pselx;
    assign off_full     = paddr - BASE_ADDR;
    // Only the offset of the setup-phase address decides the error; writes to WRCNT/ID are illegal.
    assign setup_err    = (paddr < BASE_ADDR) || (off_full >= 32'd32) || (paddr[1:0] != 2'b00)
                          || (pwrite && (off_full[4:3] == 2'b11));

    function automatic logic [31:0] read_reg(input logic [2:0] idx);
        case (idx)
            3'd6:    return wrcnt_q;
            3'd7:    return ID_VALUE;
            default: return regs_q[idx];
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        regs_d    = regs_q;
        wrcnt_d   = wrcnt_q;
        case (state_q)
            S_IDLE: begin
                if (sel && !penable) begin
                    idx_d   = off_full[4:2];
                    wr_d    = pwrite;
                    wdata_d = pwdata;
                    err_d   = setup_err;
                    if (WAIT_STATES == 0) begin
                        state_d   = S_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = setup_err;
                        prdata_d  = (!pwrite && !setup_err) ? read_reg(off_full[4:2]) : 32'd0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            S_WAIT: begin
                if (!sel) begin
                    state_d = S_IDLE;
                end else if (penable) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d   = S_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        prdata_d  = (!wr_q && !err_q) ? read_reg(idx_q) : 32'd0;
                    end
                end
            end
            S_RESP: begin
                // Commit happens only at the edge closing the completion cycle.
                if (wr_q && !err_q) begin
                    if (idx_q < 3'd6) regs_d[idx_q] = wdata_q;
                    wrcnt_d = wrcnt_q + 32'd1;
                end
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = 32'd0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= 3'd0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= 32'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'd0;
            wrcnt_q   <= 32'd0;
            for (int i = 0; i < 6; i++) regs_q[i] <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            wrcnt_q   <= wrcnt_d;
            regs_q    <= regs_d;
        end
    end

    assign prdata   = prdata_q;
    assign pready   = pready_q;
    assign pslverr  = pslverr_q;
    assign ctrl_out = regs_q[0];

endmodule

// File: doc/apb_slave_regs.md
Name: apb_slave_regs

Overview:
- APB completer (responder) at the far end of the bridge's APB port; decodes one bit of `pselx` and serves a bank of eight 32-bit registers.
- Registered PREADY with programmable wait states; PSLVERR for illegal accesses.
- Serves as the bridge's standard verification target and as the template for future peripherals.

Parameters:
- SEL_BIT, 0: index of the `pselx` bit that selects this slave (0..2).
- BASE_ADDR, 32'h8000_0000: base of the 32-byte register window.
- WAIT_STATES, 0: access-phase cycles with pready low before completion (0..15).
- ID_VALUE, 32'hA5B0_0001: constant returned by the ID register.

Ports:
- hclk  in  1  clock, rising edge.
- hresetn  in  1  reset; asynchronous assert, active-low.
- pselx  in  3  slave selects from the bridge; only bit SEL_BIT is used.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  32  byte address.
- pwdata  in  32  write data.
- prdata  out  32  read data; valid while pready = 1.
- pready  out  1  transfer completion.
- pslverr  out  1  error response; valid while pready = 1.
- ctrl_out  out  32  live copy of REG0.

Behaviour:
- Reset (hresetn = 0, any time, asynchronous):
  - prdata, pslverr, ctrl_out, REG0–REG5 and WRCNT clear to 0; pready clears to 0; FSM goes to IDLE; wait counter clears to 0.
  - Reset mid-transfer aborts the transfer with no register update.
- Notation: sel = pselx[SEL_BIT].
- Register map (offset = paddr − BASE_ADDR, word-aligned):
  - 0x00–0x14: REG0–REG5, read/write.
  - 0x18: WRCNT, read-only; counts successful writes, wraps 32'hFFFF_FFFF → 0.
  - 0x1C: ID, read-only, returns ID_VALUE.
- Error conditions (pslverr = 1 at completion), evaluated on the address captured in the setup phase:
  - paddr outside [BASE_ADDR, BASE_ADDR+0x1F];
  - paddr[1:0] != 0;
  - write to 0x18 or 0x1C.
  - An errored transfer updates no register, leaves WRCNT unchanged, and returns prdata = 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Setup detected when sel = 1 and penable = 0. At that edge, capture paddr, pwrite and pwdata, and compute the error flag.
  - If WAIT_STATES = 0: go to RESP, set pready <= 1, load prdata (reads only) and pslverr.
  - Otherwise: go to WAIT with counter <= WAIT_STATES.
  - sel = 1 with penable = 1 in IDLE (protocol violation) is ignored; stay in IDLE.
- WAIT:
  - Each cycle with sel = 1 and penable = 1, decrement the counter.
  - On the edge where the counter goes 1 → 0: go to RESP, set pready <= 1, load prdata/pslverr.
  - If sel drops: abort to IDLE, no write, pready stays 0.
- RESP (pready = 1 for exactly one cycle):
  - At the edge closing this cycle, a non-error write commits captured pwdata to its register and increments WRCNT.
  - Then pready <= 0, pslverr <= 0, prdata <= 0, and go to IDLE.
- Latency: pready is high in access cycle WAIT_STATES+1 (access cycle 1 = first cycle with penable = 1). Total transfer = WAIT_STATES+2 cycles.
- Back-to-back: a new setup in the cycle after RESP is accepted from IDLE; there are no dead cycles.
- Accesses with sel = 0 are never decoded, whatever paddr is. Outputs stay 0.
- Data stability: pwdata and paddr changing during the access phase are ignored, since the setup-phase captures are used. ctrl_out updates in the cycle after REG0's commit edge.

Test Plan:
1. Write/readback, WAIT_STATES = 0: write 32'hDEAD_BEEF to BASE+0x04, then read BASE+0x04 → pready high in access cycle 1 both times, read prdata = 32'hDEAD_BEEF, pslverr = 0, WRCNT reads 1.
2. Wait states, WAIT_STATES = 3: read BASE+0x1C → pready low for access cycles 1–3, high in cycle 4 with prdata = 32'hA5B0_0001; transfer takes 5 cycles.
3. Errors:
   - write to BASE+0x1C → pslverr = 1; ID is unchanged.
   - read BASE+0x22 → pslverr = 1, prdata = 0.
   - write BASE+0x06 (unaligned) → pslverr = 1; WRCNT is unchanged for all three.
4. Select isolation, SEL_BIT = 1: a write with pselx = 3'b001 to BASE+0x00 → pready stays 0 and REG0 stays 0. The same write with pselx = 3'b010 → ctrl_out = written value.
5. Abort and reset:
   - WAIT_STATES = 2: drop sel in access cycle 1 of a write to BASE+0x08 → REG2 unchanged, next transfer completes normally.
   - Assert hresetn = 0 mid-WAIT → all outputs 0 immediately, regs cleared.
6. Back-to-back: four consecutive writes to 0x00–0x0C with no idle cycles, then four reads → all data match, WRCNT = 4.
